// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte-wide UART transmitter with a small input FIFO.
// Bytes arrive over a valid/ready handshake, queue in a circular buffer,
// and leave on txd as 8N1 frames (start, 8 data bits LSB first, stop).
// Each bit lasts BIT_TICKS clock cycles. When a byte is waiting at the end
// of a stop bit, the next start bit follows with no idle gap.

module uart_tx_fifo #(
    parameter int BIT_TICKS  = 10417,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [7:0] din,
    input  logic       vld_tx,
    output logic       rdy_tx,
    output logic       txd,
    output logic       busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [15:0]   LAST_TICK  = 16'(BIT_TICKS - 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    // FIFO storage and bookkeeping
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] fifo_count;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic [7:0]    head;

    // Transmitter state
    state_t        state;
    state_t        state_next;
    logic [15:0]   tick_cnt;
    logic [15:0]   tick_next;
    logic [2:0]    bit_idx;
    logic [2:0]    bit_next;
    logic [7:0]    shift_reg;
    logic [7:0]    shift_next;
    logic          txd_next;

    assign full   = (fifo_count == FULL_COUNT);
    assign empty  = (fifo_count == '0);
    assign rdy_tx = !full;
    assign push   = vld_tx && !full;
    assign head   = mem[rd_ptr];
    assign busy   = (state != IDLE) || (fifo_count != '0);

    // Store the incoming byte at the write pointer; contents need no reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Advance pointers and occupancy; a push and pop together cancel out
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Transmitter registers, including the registered serial output
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            tick_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            txd       <= 1'b1;
        end else begin
            state     <= state_next;
            tick_cnt  <= tick_next;
            bit_idx   <= bit_next;
            shift_reg <= shift_next;
            txd       <= txd_next;
        end
    end

    // Next-state logic; txd_next is the line level for the cycle that follows
    always_comb begin
        state_next = state;
        tick_next  = tick_cnt;
        bit_next   = bit_idx;
        shift_next = shift_reg;
        txd_next   = txd;
        pop        = 1'b0;

        case (state)
            IDLE: begin
                tick_next = '0;
                txd_next  = 1'b1;
                if (!empty) begin
                    pop        = 1'b1;
                    shift_next = head;
                    bit_next   = '0;
                    state_next = START;
                    txd_next   = 1'b0;
                end
            end

            START: begin
                if (tick_cnt == LAST_TICK) begin
                    tick_next  = '0;
                    state_next = DATA;
                    txd_next   = shift_reg[0];
                end else begin
                    tick_next = tick_cnt + 16'd1;
                    txd_next  = 1'b0;
                end
            end

            DATA: begin
                if (tick_cnt == LAST_TICK) begin
                    tick_next  = '0;
                    shift_next = {1'b0, shift_reg[7:1]};
                    bit_next   = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        state_next = STOP;
                        txd_next   = 1'b1;
                    end else begin
                        txd_next = shift_reg[1];
                    end
                end else begin
                    tick_next = tick_cnt + 16'd1;
                    txd_next  = shift_reg[0];
                end
            end

            STOP: begin
                txd_next = 1'b1;
                if (tick_cnt == LAST_TICK) begin
                    tick_next = '0;
                    if (!empty) begin
                        pop        = 1'b1;
                        shift_next = head;
                        bit_next   = '0;
                        state_next = START;
                        txd_next   = 1'b0;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    tick_next = tick_cnt + 16'd1;
                end
            end

            default: begin
                state_next = IDLE;
                tick_next  = '0;
                txd_next   = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed bench for uart_tx_fifo.
// One instance runs with BIT_TICKS=16, another with BIT_TICKS=2. Every
// negedge records txd/busy/rdy_tx into arrays indexed by the number of the
// preceding posedge, and a behavioural UART receiver decodes the BT=16 line.

module tb_uart_tx_fifo;

    localparam int BT  = 16;
    localparam int BT2 = 2;
    localparam int NW  = 8192;

    logic       clk = 1'b0;
    logic       rstn;
    logic [7:0] din16;
    logic       vld16;
    logic       rdy16;
    logic       txd16;
    logic       busy16;
    logic [7:0] din2;
    logic       vld2;
    logic       rdy2;
    logic       txd2;
    logic       busy2;

    int n_checks = 0;
    int n_fail   = 0;
    int pcyc     = 0;

    logic wave16  [NW];
    logic wave2   [NW];
    logic busyw16 [NW];
    logic busyw2  [NW];
    logic rdyw16  [NW];

    logic [7:0] rx_q [$];
    logic       rx_prev;
    logic [7:0] rx_byte;
    logic       rx_start;

    uart_tx_fifo #(.BIT_TICKS(BT), .FIFO_DEPTH(4)) dut16 (
        .clk    (clk),
        .rstn   (rstn),
        .din    (din16),
        .vld_tx (vld16),
        .rdy_tx (rdy16),
        .txd    (txd16),
        .busy   (busy16)
    );

    uart_tx_fifo #(.BIT_TICKS(BT2), .FIFO_DEPTH(4)) dut2 (
        .clk    (clk),
        .rstn   (rstn),
        .din    (din2),
        .vld_tx (vld2),
        .rdy_tx (rdy2),
        .txd    (txd2),
        .busy   (busy2)
    );

    always #5 clk = ~clk;

    // Number the rising edges
    always @(posedge clk) pcyc <= pcyc + 1;

    // Record the outputs once per cycle, away from the active edge
    always @(negedge clk) begin
        if (pcyc < NW) begin
            wave16[pcyc]  <= txd16;
            wave2[pcyc]   <= txd2;
            busyw16[pcyc] <= busy16;
            busyw2[pcyc]  <= busy2;
            rdyw16[pcyc]  <= rdy16;
        end
    end

    // Behavioural receiver on the BT=16 line: mid-bit sampling after a fall
    initial begin
        rx_prev = 1'b1;
        forever begin
            @(negedge clk);
            if (rx_prev === 1'b1 && txd16 === 1'b0) begin
                repeat (BT / 2) @(negedge clk);
                rx_start = (txd16 === 1'b0);
                for (int i = 0; i < 8; i++) begin
                    repeat (BT) @(negedge clk);
                    rx_byte[i] = txd16;
                end
                repeat (BT) @(negedge clk);
                if (rx_start && txd16 === 1'b1) begin
                    rx_q.push_back(rx_byte);
                end
            end
            rx_prev = txd16;
        end
    end

    // Recorded-signal lookup: 0 txd16, 1 txd2, 2 busy16, 3 busy2, 4 rdy16
    function automatic logic sample(int which, int idx);
        if (idx < 0 || idx >= NW) return 1'bx;
        case (which)
            0:       return wave16[idx];
            1:       return wave2[idx];
            2:       return busyw16[idx];
            3:       return busyw2[idx];
            default: return rdyw16[idx];
        endcase
    endfunction

    function automatic bit slot_const(int which, int base, int len, logic val);
        for (int i = 0; i < len; i++) begin
            if (sample(which, base + i) !== val) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic logic [7:0] decode(int which, int base, int bt);
        logic [7:0] b;
        for (int n = 0; n < 8; n++) begin
            b[n] = sample(which, base + (n + 1) * bt);
        end
        return b;
    endfunction

    function automatic bit frame_ok(int which, int base, int bt);
        logic v;
        if (!slot_const(which, base, bt, 1'b0)) return 1'b0;
        for (int n = 0; n < 8; n++) begin
            v = sample(which, base + (n + 1) * bt);
            if (!slot_const(which, base + (n + 1) * bt, bt, v)) return 1'b0;
        end
        return slot_const(which, base + 9 * bt, bt, 1'b1);
    endfunction

    task automatic test_reset;
        rstn  = 1'b1;
        din16 = 8'h00;
        vld16 = 1'b0;
        din2  = 8'h00;
        vld2  = 1'b0;
        #2;
        rstn = 1'b0;
        #1;
        n_checks++; if (txd16 !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_txd16: got %b expected 1", txd16); end
        n_checks++; if (rdy16 !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_rdy16: got %b expected 1", rdy16); end
        n_checks++; if (busy16 !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy16: got %b expected 0", busy16); end
        n_checks++; if (txd2 !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_txd2: got %b expected 1", txd2); end
        n_checks++; if (rdy2 !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_rdy2: got %b expected 1", rdy2); end
        n_checks++; if (busy2 !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy2: got %b expected 0", busy2); end
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (4) @(negedge clk);
        n_checks++; if (txd16 !== 1'b1) begin n_fail++; $display("[TB] FAIL post_reset_txd16: got %b expected 1", txd16); end
        n_checks++; if (busy16 !== 1'b0) begin n_fail++; $display("[TB] FAIL post_reset_busy16: got %b expected 0", busy16); end
    endtask

    task automatic test_single_byte;
        int         e0;
        logic [7:0] b;
        b = 8'h55;
        @(negedge clk);
        din16 = b;
        vld16 = 1'b1;
        @(negedge clk);
        vld16 = 1'b0;
        din16 = 8'h00;
        e0 = pcyc;
        n_checks++; if (busy16 !== 1'b1) begin n_fail++; $display("[TB] FAIL single_busy_after_push: got %b expected 1", busy16); end
        repeat (175) @(negedge clk);
        n_checks++;
        if (!slot_const(0, e0 + 1, BT, 1'b0)) begin n_fail++; $display("[TB] FAIL single_start_bit: line not low for cycles E1..E1+%0d", BT - 1); end
        for (int n = 0; n < 8; n++) begin
            n_checks++;
            if (!slot_const(0, e0 + 1 + (n + 1) * BT, BT, b[n])) begin
                n_fail++;
                $display("[TB] FAIL single_data_bit%0d: got %b at slot start expected %b for %0d cycles", n, sample(0, e0 + 1 + (n + 1) * BT), b[n], BT);
            end
        end
        n_checks++;
        if (!slot_const(0, e0 + 1 + 9 * BT, BT, 1'b1)) begin n_fail++; $display("[TB] FAIL single_stop_bit: line not high for %0d cycles", BT); end
        n_checks++; if (busyw16[e0 + 160] !== 1'b1) begin n_fail++; $display("[TB] FAIL single_busy_last_stop: got %b expected 1", busyw16[e0 + 160]); end
        n_checks++; if (busyw16[e0 + 161] !== 1'b0) begin n_fail++; $display("[TB] FAIL single_busy_fall: got %b expected 0 at E1+160", busyw16[e0 + 161]); end
        n_checks++;
        if (!slot_const(0, e0 + 161, 10, 1'b1)) begin n_fail++; $display("[TB] FAIL single_idle_after: line not high after frame"); end
    endtask

    task automatic test_back_to_back;
        int         e0;
        logic [7:0] exp_b [3];
        logic [7:0] got;
        exp_b = '{8'h00, 8'hFF, 8'hA5};
        @(negedge clk);
        din16 = exp_b[0];
        vld16 = 1'b1;
        @(negedge clk);
        e0 = pcyc;
        din16 = exp_b[1];
        @(negedge clk);
        din16 = exp_b[2];
        @(negedge clk);
        vld16 = 1'b0;
        repeat (500) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            got = decode(0, e0 + 1 + 160 * i, BT);
            n_checks++;
            if (!frame_ok(0, e0 + 1 + 160 * i, BT)) begin n_fail++; $display("[TB] FAIL b2b_frame%0d_shape: frame not contiguous 8N1 at expected position", i); end
            n_checks++;
            if (got !== exp_b[i]) begin n_fail++; $display("[TB] FAIL b2b_frame%0d_data: got %h expected %h", i, got, exp_b[i]); end
        end
        n_checks++; if (busyw16[e0 + 480] !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_busy_last_stop: got %b expected 1", busyw16[e0 + 480]); end
        n_checks++; if (busyw16[e0 + 481] !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_busy_fall: got %b expected 0", busyw16[e0 + 481]); end
        n_checks++;
        if (!slot_const(0, e0 + 481, 10, 1'b1)) begin n_fail++; $display("[TB] FAIL b2b_idle_after: line not high after third frame"); end
    endtask

    task automatic test_fifo_full;
        logic [7:0] bytes_in [7];
        int         acc [7];
        int         k;
        int         guard;
        int         e0;
        logic [7:0] got;
        bytes_in = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7};
        k = 0;
        guard = 0;
        while (k < 7 && guard < 1000) begin
            @(negedge clk);
            vld16 = 1'b1;
            if (rdy16 === 1'b1) begin
                din16 = bytes_in[k];
                acc[k] = pcyc + 1;
                k++;
            end else begin
                din16 = 8'hEE;
            end
            guard++;
        end
        @(negedge clk);
        vld16 = 1'b0;
        din16 = 8'h00;
        n_checks++;
        if (k != 7) begin
            n_fail++;
            $display("[TB] FAIL full_accept_timeout: accepted %0d bytes expected 7", k);
        end else begin
            e0 = acc[0];
            n_checks++; if (acc[4] - e0 != 4) begin n_fail++; $display("[TB] FAIL full_fifth_accept: at E%0d expected E4", acc[4] - e0); end
            n_checks++; if (rdyw16[e0 + 3] !== 1'b1) begin n_fail++; $display("[TB] FAIL full_rdy_after_E3: got %b expected 1", rdyw16[e0 + 3]); end
            n_checks++; if (rdyw16[e0 + 4] !== 1'b0) begin n_fail++; $display("[TB] FAIL full_rdy_after_E4: got %b expected 0", rdyw16[e0 + 4]); end
            n_checks++; if (acc[5] - e0 != 162) begin n_fail++; $display("[TB] FAIL full_sixth_accept: at E%0d expected E162", acc[5] - e0); end
            n_checks++; if (acc[6] - e0 != 322) begin n_fail++; $display("[TB] FAIL full_seventh_accept: at E%0d expected E322", acc[6] - e0); end
            repeat (830) @(negedge clk);
            for (int i = 0; i < 7; i++) begin
                got = decode(0, e0 + 1 + 160 * i, BT);
                n_checks++;
                if (!frame_ok(0, e0 + 1 + 160 * i, BT)) begin n_fail++; $display("[TB] FAIL full_frame%0d_shape: frame not contiguous 8N1", i); end
                n_checks++;
                if (got !== bytes_in[i]) begin n_fail++; $display("[TB] FAIL full_frame%0d_data: got %h expected %h", i, got, bytes_in[i]); end
            end
            n_checks++;
            if (!slot_const(0, e0 + 1121, 20, 1'b1)) begin n_fail++; $display("[TB] FAIL full_no_extra_frame: line left idle-high state after seventh frame"); end
            n_checks++; if (busyw16[e0 + 1121] !== 1'b0) begin n_fail++; $display("[TB] FAIL full_busy_fall: got %b expected 0", busyw16[e0 + 1121]); end
        end
    endtask

    task automatic test_reset_mid_frame;
        int e0;
        int guard;
        int rel;
        @(negedge clk);
        din16 = 8'h3C;
        vld16 = 1'b1;
        @(negedge clk);
        e0 = pcyc;
        din16 = 8'h11;
        @(negedge clk);
        din16 = 8'h22;
        @(negedge clk);
        vld16 = 1'b0;
        guard = 0;
        while (pcyc < e0 + 72 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        n_checks++; if (busy16 !== 1'b1) begin n_fail++; $display("[TB] FAIL midreset_busy_before: got %b expected 1", busy16); end
        rstn = 1'b0;
        #1;
        n_checks++; if (txd16 !== 1'b1) begin n_fail++; $display("[TB] FAIL midreset_txd: got %b expected 1", txd16); end
        n_checks++; if (busy16 !== 1'b0) begin n_fail++; $display("[TB] FAIL midreset_busy: got %b expected 0", busy16); end
        n_checks++; if (rdy16 !== 1'b1) begin n_fail++; $display("[TB] FAIL midreset_rdy: got %b expected 1", rdy16); end
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        rel = pcyc;
        repeat (400) @(negedge clk);
        n_checks++;
        if (!slot_const(0, rel, 395, 1'b1)) begin n_fail++; $display("[TB] FAIL midreset_no_frames: txd left high level after reset release"); end
        n_checks++;
        if (!slot_const(2, rel, 395, 1'b0)) begin n_fail++; $display("[TB] FAIL midreset_busy_after: busy rose after reset release"); end
    endtask

    task automatic test_loopback;
        int         n0;
        logic [7:0] exp_b [3];
        exp_b = '{8'h00, 8'h7E, 8'h81};
        n0 = rx_q.size();
        @(negedge clk);
        din16 = exp_b[0];
        vld16 = 1'b1;
        @(negedge clk);
        din16 = exp_b[1];
        @(negedge clk);
        din16 = exp_b[2];
        @(negedge clk);
        vld16 = 1'b0;
        repeat (520) @(negedge clk);
        n_checks++;
        if (rx_q.size() - n0 != 3) begin
            n_fail++;
            $display("[TB] FAIL loopback_count: received %0d bytes expected 3", rx_q.size() - n0);
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (rx_q[n0 + i] !== exp_b[i]) begin n_fail++; $display("[TB] FAIL loopback_byte%0d: got %h expected %h", i, rx_q[n0 + i], exp_b[i]); end
            end
        end
    endtask

    task automatic test_bt2;
        int         e0;
        logic [7:0] got;
        @(negedge clk);
        din2 = 8'hC3;
        vld2 = 1'b1;
        @(negedge clk);
        vld2 = 1'b0;
        din2 = 8'h00;
        e0 = pcyc;
        repeat (30) @(negedge clk);
        got = decode(1, e0 + 1, BT2);
        n_checks++;
        if (!frame_ok(1, e0 + 1, BT2)) begin n_fail++; $display("[TB] FAIL bt2_shape: frame not 8N1 with 2-cycle bits"); end
        n_checks++;
        if (got !== 8'hC3) begin n_fail++; $display("[TB] FAIL bt2_data: got %h expected c3", got); end
        n_checks++; if (busyw2[e0 + 20] !== 1'b1) begin n_fail++; $display("[TB] FAIL bt2_busy_last_stop: got %b expected 1", busyw2[e0 + 20]); end
        n_checks++; if (busyw2[e0 + 21] !== 1'b0) begin n_fail++; $display("[TB] FAIL bt2_busy_fall: got %b expected 0 after 20 cycles", busyw2[e0 + 21]); end
        n_checks++;
        if (!slot_const(1, e0 + 21, 6, 1'b1)) begin n_fail++; $display("[TB] FAIL bt2_idle_after: line not high after 20-cycle frame"); end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_fifo_full();
        test_reset_mid_frame();
        test_loopback();
        test_bt2();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Byte-oriented UART transmitter for the serial debug unit. It accepts bytes over a valid/ready handshake into a small FIFO and serialises each byte onto `txd` as 8N1 frames: one start bit, eight data bits LSB first, one stop bit. It is the transmit end of the same serial link that the receive path samples. Bit timing is a fixed count of system-clock cycles.

## Interface
- `BIT_TICKS`, 10417, clk cycles per bit (100 MHz / 9600 baud); legal range 2..65535
- `FIFO_DEPTH`, 4, FIFO entries; must be a power of two, at least 2
- `clk`  input  1  system clock, rising edge
- `rstn`  input  1  reset, asynchronous, active-low
- `din`  input  8  byte to send; sampled when `vld_tx && rdy_tx`
- `vld_tx`  input  1  `din` is valid
- `rdy_tx`  output  1  FIFO can accept a byte (not full)
- `txd`  output  1  serial line, idle high, registered
- `busy`  output  1  frame in progress or FIFO non-empty

## Operation
- Push:
  - a byte is written at any rising edge with `vld_tx && rdy_tx`.
  - `rdy_tx = !full`. There is no combinational pass-through, so a pop in the same cycle does not raise `rdy_tx` while the FIFO is full.
  - `vld_tx` while `!rdy_tx` is ignored and the byte is not stored.
- FIFO:
  - circular buffer with a `log2(FIFO_DEPTH)+1`-bit count; pointers wrap modulo `FIFO_DEPTH`.
  - a simultaneous push and pop leaves the count unchanged.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE:
    - `txd=1`, tick counter held at 0.
    - when the FIFO is non-empty: pop the head into the 8-bit shift register, bit index <= 0, go to START.
  - START: `txd=0` for BIT_TICKS cycles, then go to DATA.
  - DATA:
    - `txd = shift[0]` for BIT_TICKS cycles per bit.
    - after each bit: shift right and increment the bit index.
    - after bit index 7: go to STOP.
  - STOP:
    - `txd=1` for BIT_TICKS cycles.
    - at the last tick, if the FIFO is non-empty: pop and go directly to START, so there is no idle gap.
    - otherwise go to IDLE.
- Tick counter:
  - 16 bits, counts 0..BIT_TICKS-1.
  - the state or bit advances on the edge where the counter equals BIT_TICKS-1; the counter then returns to 0.
- `busy = (state != IDLE) || (count != 0)`, registered or derived from registers only.
- The frame is exactly 10*BIT_TICKS cycles.

## Timing
- Reset values (applied asynchronously on `rstn=0`):
  - `txd=1`, `rdy_tx=1`, `busy=0`
  - FSM in IDLE, FIFO empty, counters 0, shift register 0
- Latency, with byte accepted at edge E0 into an empty FIFO while IDLE:
  - pop at E1; `txd` falls at E1.
  - start bit occupies E1..E1+BIT_TICKS.
  - data bit n begins at E1+(n+1)*BIT_TICKS.
  - stop bit begins at E1+9*BIT_TICKS.
  - with nothing queued, the FSM returns to IDLE at E1+10*BIT_TICKS.
- Back-to-back frames: the next start bit begins on the same edge that ends the previous stop bit.
- `busy` falls on the edge the FSM enters IDLE with the FIFO empty.
- Reset mid-frame: `txd` returns to 1 immediately and every queued byte is discarded. After `rstn` rises, no bit is sent until a new push.
- `din` need not be held after acceptance.

## Test plan
- Single byte, BIT_TICKS=16:
  - push 0x55 at E0.
  - `txd` is low for E1..E17 and then carries bits 1,0,1,0,1,0,1,0, each held 16 cycles.
  - stop bit high for 16 cycles, then `busy` falls at E1+160.
- Back-to-back, BIT_TICKS=16:
  - push 0x00, 0xFF, 0xA5 on consecutive cycles.
  - three frames are contiguous (480 cycles from the first start edge) with no extra high cycles between a stop bit and the next start bit.
  - the decoded bytes match the input.
- FIFO full, depth 4:
  - hold `vld_tx=1` continuously with bytes 1..7.
  - 5 bytes are accepted (byte 1 is popped at E1); `rdy_tx` falls after E4.
  - the 6th byte is accepted only after the frame-1 stop bit ends and byte 2 is popped.
  - bytes rejected while `rdy_tx=0` never appear on `txd`.
- Reset mid-frame:
  - assert `rstn=0` during data bit 3 of 0x3C with two bytes queued.
  - `txd=1`, `busy=0` and `rdy_tx=1` immediately.
  - no further frames are sent after release.
- Loopback at default BIT_TICKS:
  - drive `txd` into the link's receive path and send 0x00, 0x7E and 0x81.
  - each received byte equals the transmitted byte, and each receive is reported valid exactly once.
- Edge parameter BIT_TICKS=2:
  - push 0xC3.
  - the frame lasts exactly 20 cycles with the correct bit pattern, and counter wrap works.
